simon_datapath: RTL and testbench
=================================

# simon_datapath

Datapath for the Simon game, and the counterpart to the Simon control FSM. It holds the pattern memory, the sequence-length counter (`count`), the playback/repeat pointer (`index`) and the difficulty level. It executes the FSM's strobes and returns the three status flags the FSM branches on. It sits between the board switches/LEDs and the control block.

## Interface

Parameters:
- `PATTERN_W`, default 4: pattern width, one bit per LED/switch.
- `ADDR_W`, default 6: memory address width; depth is 2^ADDR_W = 64 entries.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `level`  in  1: difficulty switch; 0 = easy, 1 = hard.
- `pattern`  in  PATTERN_W: player switch pattern.
- `cnt_count`  in  1: increment `count`.
- `clr_count`  in  1: clear `count`.
- `cnt_index`  in  1: increment `index`.
- `clr_index`  in  1: clear `index`.
- `read_Memory`  in  1: LEDs show memory instead of switches.
- `w_en`  in  1: write `pattern` to `mem[count]`.
- `set_level`  in  1: latch `level` into `level_reg`.
- `index_lt_count`  out  1: `index < count`.
- `input_eq_pattern`  out  1: `pattern == mem[index]`.
- `is_legal`  out  1: `pattern` is a legal entry under `level_reg`.
- `pattern_leds`  out  PATTERN_W: LED drive.

## Operation

Registers:
- `count`: ADDR_W bits.
- `index`: ADDR_W bits.
- `level_reg`: 1 bit.
- `mem`: 2^ADDR_W × PATTERN_W array.

Counter rules, applied independently to `count` and `index`:
- Clear has priority over increment.
- Increment saturates at 2^ADDR_W−1; there is no wrap to 0.
- Neither clear nor increment: hold.

Level:
- `set_level` = 1: `level_reg <= level`.
- Otherwise `level_reg` holds.

Memory:
- Write: synchronous, at the edge where `w_en` = 1, `mem[count] <= pattern`.
- The write address is the pre-edge `count`. If `cnt_count` is also asserted in the same cycle, the write lands at the old `count` and `count` then increments.
- Read: asynchronous (combinational) at `index`.

Status flags (all combinational from current register, input and memory values):
- `index_lt_count` = unsigned `index < count`.
- `input_eq_pattern` = (`pattern == mem[index]`).
- `is_legal` when `level_reg` = 0: `pattern != 0`.
- `is_legal` when `level_reg` = 1: exactly one bit of `pattern` set (one-hot).

LED output:
- `pattern_leds = read_Memory ? mem[index] : pattern`.

## Timing

Reset: while `rst` = 1 at an edge:
- `count <= 0`, `index <= 0`.
- `level_reg <= level` (the level is captured at reset).
- `mem` is untouched unless `SIMON_DP_MEM_CLEAR_EN` is defined.
- `rst` overrides all strobes, including `w_en`: no write occurs in a reset cycle.

Output values right after reset:
- `index_lt_count` = 0.
- `is_legal` follows the new `level_reg`.
- `pattern_leds` = `pattern` if `read_Memory` = 0; otherwise `mem[0]`.
- `input_eq_pattern` = (`pattern == mem[0]`).

Latency:
- Strobes take effect at the next edge.
- All outputs reflect the new register state in the same cycle, with zero additional latency.

Read-during-write to the same address: the read returns old data until the edge and new data after it.

Saturation: at `count` = 63 with `index` = 63, `index_lt_count` = 0. The FSM then sees the sequence as complete and no overflow occurs.

Reset mid-playback or mid-repeat: the pointers clear next cycle and the FSM restarts in INPUT. Without the macro, stale memory contents remain but are unreachable until rewritten.

## Configuration

Macro `SIMON_DP_MEM_CLEAR_EN`:
- Defined: every `mem` entry is set to 0 at any edge with `rst` = 1, alongside the register reset.
- Undefined: `mem` has no reset, content is X after power-up, and the array maps to plain RAM.

## Test plan

- **Reset capture:** `level` = 1, `rst` = 1 for one edge, then `rst` = 0 → `count` = 0, `index` = 0, `level_reg` = 1. `pattern` = 4'b0011 gives `is_legal` = 0; 4'b0100 gives `is_legal` = 1.
- **Easy legality:** reset with `level` = 0 → `pattern` = 4'b0000 gives `is_legal` = 0; 4'b1011 gives `is_legal` = 1.
- **Write plus increment:** `w_en` + `cnt_count`, `pattern` = 4'b0010 at `count` = 0, then `w_en` with 4'b1000 at `count` = 1 → `mem[0]` = 0010, `mem[1]` = 1000, `count` = 2 (or 1 if `cnt_count` is not asserted on the second write). With `read_Memory` = 1 and `index` = 0, `pattern_leds` = 0010.
- **Playback and repeat pointers:** `count` = 2; pulse `cnt_index` twice → `index_lt_count` 1, 1, then 0 at `index` = 2. Simultaneous `clr_index` + `cnt_index` gives `index` = 0. `pattern` = `mem[index]` gives `input_eq_pattern` = 1; any other value gives 0.
- **Saturation:** 70 `cnt_count` pulses → `count` = 63 and holds. 70 `cnt_index` pulses → `index` = 63 and `index_lt_count` = 0.
- **Macro:** write 4'b1111 to `mem[5]`, then reset. With the macro, `index` = 5 gives `pattern_leds` = 0000 when `read_Memory` = 1. Without it, `pattern_leds` = 1111. In both builds, `w_en` during `rst` writes nothing.

Source files
------------

// File: rtl/simon_datapath.sv
// Simon game datapath: pattern memory, count/index pointers, difficulty level.
// Define SIMON_DP_MEM_CLEAR_EN to zero the pattern memory on reset.
module simon_datapath #(
  parameter int PATTERN_W = 4,
  parameter int ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 level,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 cnt_count,
  input  logic                 clr_count,
  input  logic                 cnt_index,
  input  logic                 clr_index,
  input  logic                 read_Memory,
  input  logic                 w_en,
  input  logic                 set_level,
  output logic                 index_lt_count,
  output logic                 input_eq_pattern,
  output logic                 is_legal,
  output logic [PATTERN_W-1:0] pattern_leds
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [ADDR_W-1:0]    count;
  logic [ADDR_W-1:0]    index;
  logic                 level_reg;
  logic [PATTERN_W-1:0] mem [DEPTH];
  logic [PATTERN_W-1:0] mem_rd;
  logic                 pat_nz;
  logic                 pat_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      index     <= '0;
      level_reg <= level;
    end else begin
      // clear wins over increment; increment sticks at the top
      if (clr_count)
        count <= '0;
      else if (cnt_count && count != PTR_MAX)
        count <= count + 1'b1;

      if (clr_index)
        index <= '0;
      else if (cnt_index && index != PTR_MAX)
        index <= index + 1'b1;

      if (set_level)
        level_reg <= level;
    end
  end

`ifdef SIMON_DP_MEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (w_en) begin
      mem[count] <= pattern;
    end
  end
`else
  // no reset on the array so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (!rst && w_en)
      mem[count] <= pattern;
  end
`endif

  assign mem_rd = mem[index];

  assign pat_nz     = |pattern;
  assign pat_onehot = pat_nz &&
                      ~|(pattern & (pattern - PATTERN_W'(1)));

  always_comb begin
    index_lt_count   = index < count;
    input_eq_pattern = pattern == mem_rd;
    is_legal         = level_reg ? pat_onehot : pat_nz;
    pattern_leds     = read_Memory ? mem_rd : pattern;
  end

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath.
// Expected outputs come from a behavioural model via a scoreboard queue.
module tb_simon_datapath;

  localparam logic [6:0] NONE = 7'h00;
  localparam logic [6:0] CC   = 7'h01;
  localparam logic [6:0] CLRC = 7'h02;
  localparam logic [6:0] CI   = 7'h04;
  localparam logic [6:0] CLRI = 7'h08;
  localparam logic [6:0] WE   = 7'h10;
  localparam logic [6:0] SL   = 7'h20;
  localparam logic [6:0] RST  = 7'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic       level;
  logic [3:0] pattern;
  logic       cnt_count;
  logic       clr_count;
  logic       cnt_index;
  logic       clr_index;
  logic       read_Memory;
  logic       w_en;
  logic       set_level;
  logic       index_lt_count;
  logic       input_eq_pattern;
  logic       is_legal;
  logic [3:0] pattern_leds;

  always #5 clk = ~clk;

  simon_datapath dut (
    .clk              (clk),
    .rst              (rst),
    .level            (level),
    .pattern          (pattern),
    .cnt_count        (cnt_count),
    .clr_count        (clr_count),
    .cnt_index        (cnt_index),
    .clr_index        (clr_index),
    .read_Memory      (read_Memory),
    .w_en             (w_en),
    .set_level        (set_level),
    .index_lt_count   (index_lt_count),
    .input_eq_pattern (input_eq_pattern),
    .is_legal         (is_legal),
    .pattern_leds     (pattern_leds)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] val;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;

  int         mcount;
  int         mindex;
  logic       mlevel;
  logic [3:0] mmem [64];
  bit         mvalid [64];
  bit         known = 0;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       return {3'b000, index_lt_count};
      1:       return {3'b000, input_eq_pattern};
      2:       return {3'b000, is_legal};
      default: return pattern_leds;
    endcase
  endfunction

  function automatic logic legal_model(input logic lv, input logic [3:0] p);
    int ones = 0;
    for (int b = 0; b < 4; b++)
      if (p[b]) ones++;
    return lv ? (ones == 1) : (ones != 0);
  endfunction

  task automatic expect_all(input string tag);
    exp_t e;
    if (!known) return;
    sb.push_back('{{tag, "_lt"}, 0, {3'b000, mindex < mcount}});
    sb.push_back('{{tag, "_legal"}, 2,
                   {3'b000, legal_model(mlevel, pattern)}});
    if (mvalid[mindex])
      sb.push_back('{{tag, "_eq"}, 1,
                     {3'b000, pattern == mmem[mindex]}});
    if (!read_Memory)
      sb.push_back('{{tag, "_leds"}, 3, pattern});
    else if (mvalid[mindex])
      sb.push_back('{{tag, "_leds"}, 3, mmem[mindex]});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] pat,
                     input logic rm, input logic [6:0] s);
    pattern     = pat;
    read_Memory = rm;
    cnt_count   = s[0];
    clr_count   = s[1];
    cnt_index   = s[2];
    clr_index   = s[3];
    w_en        = s[4];
    set_level   = s[5];
    rst         = s[6];
    #1;
    expect_all({tag, "_pre"});
    @(posedge clk);
    if (s[6]) begin
      mcount = 0;
      mindex = 0;
      mlevel = level;
      known  = 1;
`ifdef SIMON_DP_MEM_CLEAR_EN
      for (int i = 0; i < 64; i++) begin
        mmem[i]   = 4'b0000;
        mvalid[i] = 1;
      end
`endif
    end else begin
      if (s[4]) begin
        mmem[mcount]   = pat;
        mvalid[mcount] = 1;
      end
      if (s[1]) mcount = 0;
      else if (s[0] && mcount < 63) mcount++;
      if (s[3]) mindex = 0;
      else if (s[2] && mindex < 63) mindex++;
      if (s[5]) mlevel = level;
    end
    #1;
    expect_all({tag, "_post"});
    {cnt_count, clr_count, cnt_index, clr_index} = 4'b0000;
    {w_en, set_level, rst} = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mvalid[i] = 0;
    rst = 1; level = 0; pattern = 0; read_Memory = 0;
    {cnt_count, clr_count, cnt_index, clr_index} = 4'b0000;
    {w_en, set_level} = 2'b00;
    @(negedge clk);

    level = 1;
    cyc("rst_hard", 4'b0011, 0, RST);
    cyc("hard_0011", 4'b0011, 0, NONE);
    cyc("hard_0100", 4'b0100, 0, NONE);

    level = 0;
    cyc("rst_easy", 4'b0000, 0, RST);
    cyc("easy_0000", 4'b0000, 0, NONE);
    cyc("easy_1011", 4'b1011, 0, NONE);

    cyc("wr0", 4'b0010, 0, WE | CC);
    cyc("wr1", 4'b1000, 0, WE | CC);
    cyc("rd0", 4'b0010, 1, NONE);
    cyc("neq", 4'b0011, 1, NONE);

    cyc("pb1", 4'b1000, 1, CI);
    cyc("pb2", 4'b0000, 1, CI);
    cyc("iclr_pri", 4'b0010, 1, CLRI | CI);
    cyc("cclr_pri", 4'b0010, 1, CLRC | CC);

    cyc("rdw", 4'b0110, 1, WE);
    cyc("rdw_hold", 4'b0110, 1, NONE);

    level = 1;
    cyc("setlvl", 4'b0011, 0, SL);
    level = 0;
    cyc("lvl_hold", 4'b0011, 0, NONE);

    for (int i = 0; i < 70; i++)
      cyc("sat_c", 4'b0001, 0, CC);
    for (int i = 0; i < 70; i++)
      cyc("sat_i", 4'b0001, 0, CI);

    cyc("m_clrc", 4'b0000, 0, CLRC);
    for (int i = 0; i < 5; i++)
      cyc("m_cc", 4'b0000, 0, CC);
    cyc("m_wr5", 4'b1111, 0, WE);
    cyc("m_clri", 4'b0000, 0, CLRI);
    for (int i = 0; i < 5; i++)
      cyc("m_ci", 4'b0000, 1, CI);
    cyc("m_rd5", 4'b0000, 1, NONE);
    cyc("m_rst_wr", 4'b0011, 1, RST | WE);
    for (int i = 0; i < 5; i++)
      cyc("m_ci2", 4'b0000, 1, CI);
    cyc("m_after", 4'b0000, 1, NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
